// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes, datapath select codes.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWRITE = 4'd4,
    S_MEMWB    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Moore part of the control word, registered alongside the state.
  typedef struct packed {
    logic       fetch;      // in FETCH: ir_write/pc_update follow mem_ready
    logic       pc_update;  // unconditional PC write (jal)
    logic       branch;     // PC write qualified by zero (beq)
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    alu_op_e    alu_op;
  } ctrl_t;

endpackage

// File: rtl/riscv_alu_decoder.sv
// ALU control decode from alu_op class plus instruction funct fields.
// Latency: combinational.
// Backpressure: none.
// Ports: alu_op (add/sub/funct class), funct3 = IR[14:12], funct7b5 = IR[30],
//        op5 = IR[5] (separates R-type from I-type), alu_control = ALU operation code.
module riscv_alu_decoder
  import riscv_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // IR[30] is part of the immediate for addi, so only R-type may subtract.
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_control.sv
// Multicycle RV32I main control: sequences fetch/decode/execute/memory/writeback on the shared datapath.
// Latency: lw 5, sw/R/I/jal 4, beq 3, illegal 2 cycles; each memory wait cycle adds one.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until mem_ready; reset drops all write enables at once.
// Ports: clk/reset (sync, active-high); op/funct3/funct7b5 from IR; zero from ALU; mem_ready from memory;
//        pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a/b, imm_src,
//        alu_control to the datapath; illegal pulse; state_dbg = current state.
module riscv_multicycle_control
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   op_legal;
  logic   run;

  function automatic ctrl_t decode_state(input state_e s);
    ctrl_t c;
    c        = '0;
    c.alu_op = ALUOP_ADD;
    case (s)
      S_FETCH:    begin c.fetch = 1'b1; c.alu_src_b = SRCB_FOUR; c.result_src = RES_ALURESULT; end
      // Branch/jump target is precomputed into ALUOut from OldPC + imm.
      S_DECODE:   begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM; end
      S_MEMADR:   begin c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_IMM; end
      S_MEMREAD:  begin c.adr_src = 1'b1; c.result_src = RES_ALUOUT; end
      S_MEMWRITE: begin c.adr_src = 1'b1; c.result_src = RES_ALUOUT; c.mem_write = 1'b1; end
      S_MEMWB:    begin c.result_src = RES_DATA; c.reg_write = 1'b1; end
      S_EXECUTER: begin c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_RS2; c.alu_op = ALUOP_FUNCT; end
      S_EXECUTEI: begin c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_IMM; c.alu_op = ALUOP_FUNCT; end
      S_ALUWB:    begin c.result_src = RES_ALUOUT; c.reg_write = 1'b1; end
      S_BEQ:      begin c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_RS2; c.alu_op = ALUOP_SUB;
                        c.result_src = RES_ALUOUT; c.branch = 1'b1; end
      // OldPC + 4 becomes the link value; ALUOut (target) goes to the PC.
      S_JAL:      begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_FOUR;
                        c.result_src = RES_ALUOUT; c.pc_update = 1'b1; end
      default:    c.alu_op = ALUOP_ADD;
    endcase
    return c;
  endfunction

  always_comb begin
    case (op)
      OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL: op_legal = 1'b1;
      default:                                          op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTER;
          OP_ITYPE:     state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
    ctrl_d = decode_state(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= decode_state(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Enables are gated by reset combinationally so an in-flight store is cut off the same cycle.
  assign run        = ~reset;
  assign ir_write   = ctrl_q.fetch & mem_ready & run;
  assign pc_write   = ((ctrl_q.fetch & mem_ready) | ctrl_q.pc_update | (ctrl_q.branch & zero)) & run;
  assign mem_write  = ctrl_q.mem_write & run;
  assign reg_write  = ctrl_q.reg_write & run;
  assign illegal    = (state_q == S_DECODE) & ~op_legal & run;
  assign adr_src    = ctrl_q.adr_src;
  assign result_src = ctrl_q.result_src;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign state_dbg  = state_q;

  always_comb begin
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

  riscv_alu_decoder u_alu_dec (
    .alu_op      (ctrl_q.alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_riscv_multicycle_control.sv
// Bench for riscv_multicycle_control: directed scenarios plus random instruction streams.
// Latency: n/a.
// Backpressure: random mem_ready stalls.
module tb_riscv_multicycle_control;
  import riscv_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = OP_ITYPE;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state_dbg;

  int total = 0;
  int bad   = 0;

  riscv_multicycle_control dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control), .illegal(illegal), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       pcw, irw, rgw, mw, ill, adr;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] alu;
    logic       alu_chk;
  } exp_t;

  state_e path[$];

  function automatic void build_path(input logic [6:0] o);
    path = {};
    path.push_back(S_FETCH);
    path.push_back(S_DECODE);
    case (o)
      OP_LW:    begin path.push_back(S_MEMADR); path.push_back(S_MEMREAD); path.push_back(S_MEMWB); end
      OP_SW:    begin path.push_back(S_MEMADR); path.push_back(S_MEMWRITE); end
      OP_RTYPE: begin path.push_back(S_EXECUTER); path.push_back(S_ALUWB); end
      OP_ITYPE: begin path.push_back(S_EXECUTEI); path.push_back(S_ALUWB); end
      OP_BEQ:   path.push_back(S_BEQ);
      OP_JAL:   begin path.push_back(S_JAL); path.push_back(S_ALUWB); end
      default:  ;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o == OP_RTYPE && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic exp_t expect_outputs(input state_e s, input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7, input logic mr, input logic z);
    exp_t e;
    logic legal;
    e = '0;
    legal = (o == OP_LW) || (o == OP_SW) || (o == OP_RTYPE) || (o == OP_ITYPE) ||
            (o == OP_BEQ) || (o == OP_JAL);
    case (s)
      S_FETCH:    begin e.sb = 2'b10; e.res = 2'b10; e.irw = mr; e.pcw = mr; e.alu_chk = 1'b1; end
      S_DECODE:   begin e.sa = 2'b01; e.sb = 2'b01; e.ill = !legal; e.alu_chk = 1'b1; end
      S_MEMADR:   begin e.sa = 2'b10; e.sb = 2'b01; e.alu_chk = 1'b1; end
      S_MEMREAD:  e.adr = 1'b1;
      S_MEMWRITE: begin e.adr = 1'b1; e.mw = 1'b1; end
      S_MEMWB:    begin e.res = 2'b01; e.rgw = 1'b1; end
      S_EXECUTER: begin e.sa = 2'b10; e.sb = 2'b00; e.alu = funct_alu(o, f3, f7); e.alu_chk = 1'b1; end
      S_EXECUTEI: begin e.sa = 2'b10; e.sb = 2'b01; e.alu = funct_alu(o, f3, f7); e.alu_chk = 1'b1; end
      S_ALUWB:    e.rgw = 1'b1;
      S_BEQ:      begin e.sa = 2'b10; e.alu = 3'b001; e.alu_chk = 1'b1; e.pcw = z; end
      S_JAL:      begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
      default:    ;
    endcase
    e.imm = (o == OP_SW) ? 2'b01 : (o == OP_BEQ) ? 2'b10 : (o == OP_JAL) ? 2'b11 : 2'b00;
    return e;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; op = OP_SW;
    #1;
    total++;
    if ({pc_write, ir_write, reg_write, mem_write, illegal} !== 5'b0) begin
      bad++; $display("FAIL reset_enables: got %b want 00000", {pc_write, ir_write, reg_write, mem_write, illegal});
    end
    cyc();
    reset = 1'b0; mem_ready = 1'b0; op = OP_ITYPE;
    #1;
    total++;
    if (state_dbg !== S_FETCH) begin bad++; $display("FAIL reset_state: got %0d want %0d", state_dbg, S_FETCH); end
    total++;
    if ({adr_src, alu_src_b, result_src} !== 5'b0_10_10) begin
      bad++; $display("FAIL reset_selects: got %b want 01010", {adr_src, alu_src_b, result_src});
    end
    cyc();
  endtask

  task automatic test_addi();
    state_e exp_seq[5] = '{S_FETCH, S_DECODE, S_EXECUTEI, S_ALUWB, S_FETCH};
    op = OP_ITYPE; funct3 = 3'b000; funct7b5 = 1'b0; mem_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if (state_dbg !== exp_seq[k]) begin bad++; $display("FAIL addi_state[%0d]: got %0d want %0d", k, state_dbg, exp_seq[k]); end
      total++;
      if (reg_write !== (k == 3)) begin bad++; $display("FAIL addi_reg_write[%0d]: got %b want %b", k, reg_write, (k == 3)); end
      if (k == 2) begin
        total++;
        if (alu_control !== 3'b000) begin bad++; $display("FAIL addi_alu: got %b want 000", alu_control); end
      end
      if (k == 4) mem_ready = 1'b0;
      cyc();
    end
  endtask

  task automatic test_fetch_wait();
    op = OP_RTYPE; funct3 = 3'b000; funct7b5 = 1'b0; mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if ({state_dbg, ir_write, pc_write} !== {4'(S_FETCH), 2'b00}) begin
        bad++; $display("FAIL fetch_hold[%0d]: got state %0d ir %b pc %b want state 0 ir 0 pc 0", k, state_dbg, ir_write, pc_write);
      end
      cyc();
    end
    mem_ready = 1'b1;
    #1;
    total++;
    if ({ir_write, pc_write} !== 2'b11) begin bad++; $display("FAIL fetch_ready: got %b want 11", {ir_write, pc_write}); end
    cyc();
    #1;
    total++;
    if ({state_dbg, ir_write} !== {4'(S_DECODE), 1'b0}) begin
      bad++; $display("FAIL fetch_once: got state %0d ir %b want state 1 ir 0", state_dbg, ir_write);
    end
    cyc(); cyc(); mem_ready = 1'b0; cyc();
  endtask

  task automatic test_alu_funct();
    logic [6:0] t_op[5]  = '{OP_RTYPE, OP_RTYPE, OP_ITYPE, OP_RTYPE, OP_ITYPE};
    logic [2:0] t_f3[5]  = '{3'b000,   3'b010,   3'b000,   3'b110,   3'b111};
    logic       t_f7[5]  = '{1'b1,     1'b1,     1'b1,     1'b0,     1'b1};
    logic [2:0] t_exp[5] = '{3'b001,   3'b101,   3'b000,   3'b011,   3'b010};
    for (int k = 0; k < 5; k++) begin
      op = t_op[k]; funct3 = t_f3[k]; funct7b5 = t_f7[k]; mem_ready = 1'b1;
      cyc(); cyc();
      #1;
      total++;
      if (alu_control !== t_exp[k]) begin bad++; $display("FAIL alu_funct[%0d]: got %b want %b", k, alu_control, t_exp[k]); end
      cyc(); mem_ready = 1'b0; cyc();
    end
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      op = OP_BEQ; mem_ready = 1'b1; zero = 1'b0;
      cyc(); cyc();
      zero = z[0];
      #1;
      total++;
      if ({state_dbg, pc_write, imm_src} !== {4'(S_BEQ), z[0], 2'b10}) begin
        bad++; $display("FAIL beq_z%0d: got state %0d pc %b imm %b want state 9 pc %0d imm 10", z, state_dbg, pc_write, imm_src, z);
      end
      mem_ready = 1'b0;
      cyc();
      total++;
      if (state_dbg !== S_FETCH) begin bad++; $display("FAIL beq_len_z%0d: got %0d want %0d", z, state_dbg, S_FETCH); end
      zero = 1'b0;
    end
  endtask

  task automatic test_lw_wait();
    int n = 0;
    op = OP_LW; mem_ready = 1'b1;
    cyc(); cyc(); cyc(); n = 3;                  // now in MEMREAD
    mem_ready = 1'b0;
    cyc(); cyc(); n += 2;
    mem_ready = 1'b1;
    #1;
    total++;
    if (state_dbg !== S_MEMREAD) begin bad++; $display("FAIL lw_stall: got %0d want %0d", state_dbg, S_MEMREAD); end
    cyc(); n++;
    total++;
    if ({state_dbg, result_src, reg_write} !== {4'(S_MEMWB), 2'b01, 1'b1}) begin
      bad++; $display("FAIL lw_memwb: got state %0d res %b rw %b want state 5 res 01 rw 1", state_dbg, result_src, reg_write);
    end
    mem_ready = 1'b0;
    cyc(); n++;
    total++;
    if (state_dbg !== S_FETCH || n != 7) begin bad++; $display("FAIL lw_len: got state %0d after %0d want state 0 after 7", state_dbg, n); end
  endtask

  task automatic test_sw_reset();
    op = OP_SW; mem_ready = 1'b1;
    cyc(); cyc(); cyc();
    mem_ready = 1'b0;
    #1;
    total++;
    if ({state_dbg, mem_write, adr_src} !== {4'(S_MEMWRITE), 2'b11}) begin
      bad++; $display("FAIL sw_memwrite: got state %0d mw %b adr %b want state 4 mw 1 adr 1", state_dbg, mem_write, adr_src);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({mem_write, pc_write, reg_write, ir_write} !== 4'b0) begin
      bad++; $display("FAIL sw_reset_drop: got %b want 0000", {mem_write, pc_write, reg_write, ir_write});
    end
    cyc();
    reset = 1'b0;
    #1;
    total++;
    if (state_dbg !== S_FETCH) begin bad++; $display("FAIL sw_reset_fetch: got %0d want %0d", state_dbg, S_FETCH); end
    cyc();
  endtask

  task automatic test_illegal();
    op = 7'h7F; mem_ready = 1'b1;
    cyc();
    #1;
    total++;
    if ({state_dbg, illegal, pc_write, ir_write, reg_write, mem_write} !== {4'(S_DECODE), 5'b10000}) begin
      bad++; $display("FAIL illegal_decode: got state %0d ill/pc/ir/rw/mw %b want state 1 10000",
                      state_dbg, {illegal, pc_write, ir_write, reg_write, mem_write});
    end
    mem_ready = 1'b0;
    cyc();
    total++;
    if ({state_dbg, illegal} !== {4'(S_FETCH), 1'b0}) begin
      bad++; $display("FAIL illegal_after: got state %0d ill %b want state 0 ill 0", state_dbg, illegal);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops[9] = '{OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL, 7'h7F, 7'h37, 7'h00};
    for (int i = 0; i < 60; i++) begin
      int idx = 0;
      int guard = 0;
      op = ops[$urandom_range(0, 8)];
      funct3 = 3'($urandom_range(0, 7));
      funct7b5 = 1'($urandom_range(0, 1));
      build_path(op);
      while (idx < path.size() && guard < 40) begin
        exp_t e;
        mem_ready = ($urandom_range(0, 3) != 0);
        zero = 1'($urandom_range(0, 1));
        #1;
        e = expect_outputs(path[idx], op, funct3, funct7b5, mem_ready, zero);
        total++;
        if (state_dbg !== path[idx]) begin bad++; $display("FAIL rnd_state i%0d: got %0d want %0d", i, state_dbg, path[idx]); end
        total++;
        if ({pc_write, ir_write, reg_write, mem_write, illegal} !== {e.pcw, e.irw, e.rgw, e.mw, e.ill}) begin
          bad++; $display("FAIL rnd_enables i%0d st%0d: got %b want %b", i, path[idx],
                          {pc_write, ir_write, reg_write, mem_write, illegal}, {e.pcw, e.irw, e.rgw, e.mw, e.ill});
        end
        total++;
        if ({adr_src, result_src, alu_src_a, alu_src_b, imm_src} !== {e.adr, e.res, e.sa, e.sb, e.imm}) begin
          bad++; $display("FAIL rnd_selects i%0d st%0d: got %b want %b", i, path[idx],
                          {adr_src, result_src, alu_src_a, alu_src_b, imm_src}, {e.adr, e.res, e.sa, e.sb, e.imm});
        end
        if (e.alu_chk) begin
          total++;
          if (alu_control !== e.alu) begin bad++; $display("FAIL rnd_alu i%0d st%0d: got %b want %b", i, path[idx], alu_control, e.alu); end
        end
        if (!((path[idx] == S_FETCH || path[idx] == S_MEMREAD || path[idx] == S_MEMWRITE) && !mem_ready))
          idx++;
        guard++;
        cyc();
      end
      if (guard >= 40) begin
        total++; bad++;
        $display("FAIL rnd_timeout i%0d: got %0d cycles want completion under 40", i, guard);
      end
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_fetch_wait();
    test_alu_funct();
    test_beq();
    test_lw_wait();
    test_sw_reset();
    test_illegal();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_multicycle_control.md
# riscv_multicycle_control

Main control unit for the multicycle RV32I processor variant. It sequences the shared datapath (PC, instruction register, single unified memory, register file, ALU) through fetch/decode/execute/memory/writeback states. It also decodes ALU and immediate controls and stretches memory states with wait cycles via a ready handshake. It sits inside `processor` beside `data_path` and replaces the single-cycle combinational controller.

## Interface
- No parameters; the ISA subset is fixed: lw, sw, R-type ALU, I-type ALU, beq, jal.
- `clk` in 1: system clock, rising-edge.
- `reset` in 1: synchronous, active-high.
- `op` in 7: IR[6:0].
- `funct3` in 3: IR[14:12].
- `funct7b5` in 1: IR[30].
- `zero` in 1: ALU zero flag, same cycle.
- `mem_ready` in 1: unified memory has completed the current access.
- `pc_write` out 1: PC register enable.
- `adr_src` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_write` out 1: memory write strobe.
- `ir_write` out 1: IR and OldPC enable.
- `reg_write` out 1: register file write.
- `result_src` out 2: 00 ALUOut, 01 Data, 10 ALUResult.
- `alu_src_a` out 2: 00 PC, 01 OldPC, 10 rs1.
- `alu_src_b` out 2: 00 rs2, 01 imm, 10 constant 4.
- `imm_src` out 2: 00 I, 01 S, 10 B, 11 J.
- `alu_control` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `illegal` out 1: one-cycle pulse on an unsupported opcode.
- `state_dbg` out 4: current state encoding, for the testbench.

## Operation
- States and transitions:
  - FETCH→DECODE when `mem_ready`; otherwise hold in FETCH.
  - DECODE, by `op`:
    - 0000011 or 0100011 → MEMADR.
    - 0110011 → EXECUTER.
    - 0010011 → EXECUTEI.
    - 1100011 → BEQ.
    - 1101111 → JAL.
    - Any other opcode → FETCH, with `illegal`=1.
  - MEMADR→MEMREAD for lw, →MEMWRITE for sw.
  - MEMREAD→MEMWB when `mem_ready`; otherwise hold.
  - MEMWRITE→FETCH when `mem_ready`; otherwise hold.
  - EXECUTER and EXECUTEI→ALUWB.
  - JAL→ALUWB.
  - MEMWB, ALUWB and BEQ→FETCH.
- Per-state outputs. Unlisted enables are 0 and unlisted selects are 00.
  - FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op add, result_src=10. `ir_write` and the internal `pc_update` equal `mem_ready`.
  - DECODE: alu_src_a=01, alu_src_b=01, alu_op add. This computes the branch/jump target into ALUOut.
  - MEMADR: alu_src_a=10, alu_src_b=01, alu_op add.
  - MEMREAD: adr_src=1, result_src=00.
  - MEMWRITE: adr_src=1, result_src=00, `mem_write`=1 every cycle held.
  - MEMWB: result_src=01, reg_write=1.
  - EXECUTER: alu_src_a=10, alu_src_b=00, alu_op funct.
  - EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op funct.
  - ALUWB: result_src=00, reg_write=1.
  - BEQ: alu_src_a=10, alu_src_b=00, alu_op sub, result_src=00, branch=1.
  - JAL: alu_src_a=01, alu_src_b=10, result_src=00, pc_update=1.
- Output equation: `pc_write = pc_update | (branch & zero)`.
- `imm_src` is decoded from `op` in every state: sw→01, beq→10, jal→11, otherwise 00.
- ALU decode:
  - alu_op add → 000; alu_op sub → 001.
  - alu_op funct, funct3=000 → 001 only when op[5] & funct7b5 (R-type sub); otherwise 000. An I-type addi with IR[30]=1 is still add.
  - funct3 010→101, 110→011, 111→010; any other funct3 → 000.

## Timing
- The state register updates on the rising edge. Outputs are Moore decodes of the state, except `ir_write`, `pc_update` and `pc_write`, which combine with `mem_ready`/`zero` in the same cycle.
- Zero-wait cycle counts:
  - lw: 5 cycles.
  - sw, R-type, I-type, jal: 4 cycles.
  - beq: 3 cycles.
  - Illegal opcode: 2 cycles.
- Each cycle of `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- While `reset`=1, all of `pc_write`, `ir_write`, `reg_write`, `mem_write` and `illegal` are forced to 0. The state becomes FETCH on the next edge.
- Reset mid-operation, including mid-MEMWRITE, drops `mem_write` in the same cycle. The in-flight instruction is abandoned.
- First post-reset cycle: state FETCH, adr_src=0, alu_src_b=10, result_src=10.
- `illegal` is asserted only in DECODE, for exactly one cycle.

## Structure
- Shared package `riscv_pkg` holds:
  - The state enum (4-bit).
  - Opcode constants.
  - alu_op, alu_control, result_src, alu_src_a/b and imm_src encodings.
- Sub-module `riscv_alu_decoder` is combinational: alu_op, funct3, funct7b5 and op[5] in, alu_control out.
- The FSM and output decode live in the top module.

## Test plan
- Reset, then addi x5,x0,5 (0x00500293) with mem_ready=1:
  - Required state sequence: FETCH, DECODE, EXECUTEI, ALUWB, FETCH.
  - reg_write=1 only in cycle 4; alu_control=000.
- mem_ready=0 for 3 cycles in FETCH:
  - State holds and ir_write=pc_write=0.
  - ir_write=1 for exactly one cycle once ready.
- sub x4,x5,x6 (0x40628233): alu_control=001 in EXECUTER. With funct3=010 instead: 101.
- beq:
  - zero=1 gives pc_write=1 in BEQ; zero=0 gives pc_write=0.
  - Total 3 cycles, imm_src=10.
- lw with mem_ready low for 2 cycles in MEMREAD:
  - 7 cycles total; result_src=01 in MEMWB.
  - sw with reset asserted mid-MEMWRITE: mem_write=0 the same cycle, FETCH next.
- Opcode 0x7F: illegal=1 for one cycle in DECODE, no write enables asserted, FETCH next.
